// File: rtl/uart_rx_byte.sv
// 8N1 UART deserialiser with frame-error and end-of-input idle pulses; rx_valid ~2+CLKS_PER_BIT/2+9*CLKS_PER_BIT+1 cycles after start edge.
// No backpressure: every output is a one-cycle pulse, and rx_data holds its value until the next good byte.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 868,
    parameter int IDLE_BITS    = 20
) (
    input  logic       clock,
    input  logic       clear_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_error,
    output logic       rx_idle
);

    localparam int CW         = $clog2(CLKS_PER_BIT);
    localparam int IDLE_LIMIT = IDLE_BITS * CLKS_PER_BIT;
    localparam int IW         = $clog2(IDLE_LIMIT + 1);

    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_LIMIT);
    localparam logic [IW-1:0] IDLE_M1  = IW'(IDLE_LIMIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta, rxs;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_d;
    logic          valid_d, ferr_d, idle_d;
    logic          idle_armed, armed_d;
    logic [IW-1:0] idle_cnt, idle_cnt_d;

    // Synchroniser presets high so reset release never looks like a start bit.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            rx_meta     <= 1'b1;
            rxs         <= 1'b1;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            rx_idle     <= 1'b0;
            idle_armed  <= 1'b0;
            idle_cnt    <= '0;
        end else begin
            rx_meta     <= uart_rx;
            rxs         <= rx_meta;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data     <= data_d;
            rx_valid    <= valid_d;
            frame_error <= ferr_d;
            rx_idle     <= idle_d;
            idle_armed  <= armed_d;
            idle_cnt    <= idle_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q + CW'(1);
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        data_d     = rx_data;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        idle_d     = 1'b0;
        armed_d    = idle_armed;
        idle_cnt_d = idle_cnt;

        case (state_q)
            S_IDLE: begin
                bit_cnt_d = '0;
                if (!rxs) state_d = S_START;
            end
            S_START: begin
                if (bit_cnt_q == HALF_M1) begin
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_cnt_q == FULL_M1) begin
                    bit_cnt_d = '0;
                    shift_d   = {rxs, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                // Sampled mid-stop-bit, so a back-to-back start edge is still ahead.
                if (bit_cnt_q == FULL_M1) begin
                    bit_cnt_d = '0;
                    if (rxs) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        armed_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                bit_cnt_d = '0;
                if (rxs) state_d = S_IDLE;
            end
            default: begin
                bit_cnt_d = '0;
                state_d   = S_IDLE;
            end
        endcase

        // Idle pulse fires on the transition into saturation, once per armed gap.
        if (!rxs) begin
            idle_cnt_d = '0;
        end else if (state_q == S_IDLE && idle_cnt != IDLE_MAX) begin
            idle_cnt_d = idle_cnt + IW'(1);
            if (idle_cnt == IDLE_M1 && idle_armed) begin
                idle_d  = 1'b1;
                armed_d = 1'b0;
            end
        end
    end

endmodule
